// File: rtl/led_fade_driver_if.sv
// LED drive bundle between the pattern sequencer side (master) and the fade driver (slave).
interface led_fade_driver_if;
    logic [3:0] led_in;
    logic [3:0] led_out;
    logic       busy;

    modport master (output led_in, input led_out, input busy);
    modport slave  (input led_in, output led_out, output busy);
endinterface

// File: rtl/led_fade_driver.sv
// Four-channel PWM fade stage for the active-low sequencer pattern; each channel ramps OFF<->ON linearly.
// Define LED_FADE_GAMMA_EN to use a quadratic (perceptual) duty curve instead of duty = level.
module led_fade_driver #(
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned STEP_CYCLES = 19531
) (
    input logic              clk,
    input logic              rst_n,
    led_fade_driver_if.slave io
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned PS_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] LMAX    = '1;
    localparam logic [PWM_BITS-1:0] LMAX_M1 = LMAX - 1'b1;
    localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        CH_OFF,
        CH_RISE,
        CH_ON,
        CH_FALL
    } ch_state_e;

    ch_state_e           state_q [NCH];
    ch_state_e           state_d [NCH];
    logic [PWM_BITS-1:0] level_q [NCH];
    logic [PWM_BITS-1:0] level_d [NCH];
    logic [PWM_BITS-1:0] duty    [NCH];

    logic [PS_W-1:0]     prescaler_q, prescaler_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NCH-1:0]      led_out_q, led_out_d;
    logic                busy_q, busy_d;
    logic                step_tick;
    logic [NCH-1:0]      req;

    assign req = ~io.led_in;

    always_comb begin
        step_tick   = (prescaler_q == PS_LAST);
        prescaler_d = step_tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq [NCH];

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            level_sq[i] = (2*PWM_BITS)'(level_q[i]) * (2*PWM_BITS)'(level_q[i]);
            duty[i]     = PWM_BITS'(level_sq[i] >> PWM_BITS);
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            duty[i] = level_q[i];
        end
    end
`endif

    // A request reversal always beats a coincident step, so the level freezes for that edge.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            case (state_q[i])
                CH_OFF: begin
                    level_d[i] = '0;
                    if (req[i]) state_d[i] = CH_RISE;
                end
                CH_RISE: begin
                    if (!req[i]) begin
                        state_d[i] = CH_FALL;
                    end else if (step_tick) begin
                        level_d[i] = level_q[i] + 1'b1;
                        if (level_q[i] == LMAX_M1) state_d[i] = CH_ON;
                    end
                end
                CH_ON: begin
                    level_d[i] = LMAX;
                    if (!req[i]) state_d[i] = CH_FALL;
                end
                CH_FALL: begin
                    if (req[i]) begin
                        state_d[i] = CH_RISE;
                    end else if (step_tick) begin
                        level_d[i] = level_q[i] - 1'b1;
                        if (level_q[i] == LVL_ONE) state_d[i] = CH_OFF;
                    end
                end
                default: begin
                    state_d[i] = CH_OFF;
                    level_d[i] = '0;
                end
            endcase
        end
    end

    always_comb begin
        led_out_d = '1;
        busy_d    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            case (state_q[i])
                CH_OFF:  led_out_d[i] = 1'b1;
                CH_ON:   led_out_d[i] = 1'b0;
                default: begin
                    led_out_d[i] = (pwm_cnt_q < duty[i]) ? 1'b0 : 1'b1;
                    busy_d       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
            led_out_q   <= '1;
            busy_q      <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= CH_OFF;
                level_q[i] <= '0;
            end
        end else begin
            prescaler_q <= prescaler_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_out_q   <= led_out_d;
            busy_q      <= busy_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
            end
        end
    end

    assign io.led_out = led_out_q;
    assign io.busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4, STEP_CYCLES=4; honours LED_FADE_GAMMA_EN.
module tb_led_fade_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    led_fade_driver_if bus ();

    led_fade_driver #(.PWM_BITS(4), .STEP_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; outputs after edge c reflect pre-edge pwm_cnt (c-1)%16 and tick on c%4==0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic int duty_of(input int lvl);
`ifdef LED_FADE_GAMMA_EN
        return (lvl * lvl) >> 4;
`else
        return lvl;
`endif
    endfunction

    function automatic logic pwm_bit(input int lvl, input int c);
        return (((c - 1) % 16) < duty_of(lvl)) ? 1'b0 : 1'b1;
    endfunction

    task automatic reset_dut();
        bus.led_in = 4'b1111;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus.led_in = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (bus.led_out !== 4'b1111) begin errors++; $display("FAIL reset_led got %b exp 1111", bus.led_out); end
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        end
        @(negedge clk);
        bus.led_in = 4'b1111;
        rst_n = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            checks++;
            if (bus.led_out !== 4'b1111) begin errors++; $display("FAIL idle_led got %b exp 1111 cyc %0d", bus.led_out, cyc); end
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0 cyc %0d", bus.busy, cyc); end
        end
    endtask

    task automatic test_rise();
        logic [3:0] exp_led;
        logic       exp_busy;
        reset_dut();
        bus.led_in = 4'b1110;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cyc == 1) begin
                exp_led = 4'b1111; exp_busy = 1'b0;
            end else if (cyc <= 60) begin
                exp_led = {3'b111, pwm_bit((cyc - 1) / 4, cyc)}; exp_busy = 1'b1;
            end else begin
                exp_led = 4'b1110; exp_busy = 1'b0;
            end
            checks++;
            if (bus.led_out !== exp_led) begin errors++; $display("FAIL rise_led got %b exp %b cyc %0d", bus.led_out, exp_led, cyc); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL rise_busy got %b exp %b cyc %0d", bus.busy, exp_busy, cyc); end
        end
    endtask

    // Toggling the request every edge freezes the level at 8 while staying in RISE/FALL.
    task automatic test_pwm_duty();
        int lows;
        int e;
        reset_dut();
        bus.led_in = 4'b1110;
        repeat (32) @(negedge clk);
        lows = 0;
        for (int n = 0; n < 48; n++) begin
            e = cyc;
            if (e >= 33) begin
                checks++;
                if (bus.led_out !== {3'b111, pwm_bit(8, e)}) begin
                    errors++; $display("FAIL pwm_led got %b exp %b cyc %0d", bus.led_out, {3'b111, pwm_bit(8, e)}, e);
                end
                checks++;
                if (bus.busy !== 1'b1) begin errors++; $display("FAIL pwm_busy got %b exp 1 cyc %0d", bus.busy, e); end
                if (e <= 48 && bus.led_out[0] == 1'b0) lows++;
            end
            bus.led_in = (e % 2 == 0) ? 4'b1111 : 4'b1110;
            @(negedge clk);
        end
        checks++;
        if (lows !== duty_of(8)) begin errors++; $display("FAIL pwm_low_count got %0d exp %0d", lows, duty_of(8)); end
        bus.led_in = 4'b1111;
    endtask

    task automatic test_reversal();
        logic [3:0] exp_led;
        logic       exp_busy;
        int         e;
        reset_dut();
        bus.led_in = 4'b1110;
        repeat (31) @(negedge clk);
        bus.led_in = 4'b1111;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            e = cyc;
            if (e <= 32) begin
                exp_led = {3'b111, pwm_bit((e - 1) / 4, e)}; exp_busy = 1'b1;
            end else if (e <= 60) begin
                exp_led = {3'b111, pwm_bit(7 - (e - 33) / 4, e)}; exp_busy = 1'b1;
            end else begin
                exp_led = 4'b1111; exp_busy = 1'b0;
            end
            checks++;
            if (bus.led_out !== exp_led) begin errors++; $display("FAIL rev_led got %b exp %b cyc %0d", bus.led_out, exp_led, e); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL rev_busy got %b exp %b cyc %0d", bus.busy, exp_busy, e); end
        end
    endtask

    task automatic test_sequencer();
        logic [3:0] exp_led;
        logic [3:0] one;
        logic       exp_busy;
        int         c, seg, o, r;
        reset_dut();
        one = 4'b0001;
        for (int n = 0; n <= 800; n++) begin
            c = cyc;
            if (c == 0) begin
                exp_led = 4'b1111; exp_busy = 1'b0;
            end else begin
                seg = (c - 1) / 200;
                o   = c - 200 * seg;
                if (o == 1) begin
                    exp_led  = (seg == 0) ? 4'b1111 : ~(one << (seg - 1));
                    exp_busy = 1'b0;
                end else if (o <= 60) begin
                    r = (o - 1) / 4;
                    exp_led = 4'b1111;
                    exp_led[seg] = pwm_bit(r, c);
                    if (seg > 0) exp_led[seg - 1] = pwm_bit(15 - r, c);
                    exp_busy = 1'b1;
                end else begin
                    exp_led = ~(one << seg); exp_busy = 1'b0;
                end
            end
            checks++;
            if (bus.led_out !== exp_led) begin errors++; $display("FAIL seq_led got %b exp %b cyc %0d", bus.led_out, exp_led, c); end
            checks++;
            if (bus.busy !== exp_busy) begin errors++; $display("FAIL seq_busy got %b exp %b cyc %0d", bus.busy, exp_busy, c); end
            if (c % 200 == 0 && c < 800) bus.led_in = ~(one << (c / 200));
            @(negedge clk);
        end
        checks++;
        if (bus.led_out !== 4'b0111) begin errors++; $display("FAIL seq_final got %b exp 0111", bus.led_out); end
    endtask

    task automatic test_reset_mid_ramp();
        logic [3:0] exp_led;
        reset_dut();
        bus.led_in = 4'b1110;
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.led_out !== 4'b1111) begin errors++; $display("FAIL midrst_led got %b exp 1111", bus.led_out); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            exp_led = (cyc == 1) ? 4'b1111 : {3'b111, pwm_bit((cyc - 1) / 4, cyc)};
            checks++;
            if (bus.led_out !== exp_led) begin errors++; $display("FAIL restart_led got %b exp %b cyc %0d", bus.led_out, exp_led, cyc); end
        end
        bus.led_in = 4'b1111;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b1;
        bus.led_in = 4'b1111;
        #1 rst_n   = 1'b0;
        test_reset();
        test_rise();
        test_pwm_duty();
        test_reversal();
        test_sequencer();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
